// File: rtl/ship_placer_if.sv
// rtl/ship_placer_if.sv - request/response and board-memory port bundle for ship_placer
interface ship_placer_if #(
    parameter int XW = 4,
    parameter int YW = 4,
    parameter int DW = 2
) ();
    logic          start;
    logic [XW-1:0] x_pos;
    logic [YW-1:0] y_pos;
    logic [2:0]    ship_len;
    logic          vertical;
    logic          busy;
    logic          done;
    logic          ok;
    logic [XW+YW-1:0] mem_addr;
    logic          mem_w_nr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output start, x_pos, y_pos, ship_len, vertical, mem_rdata,
        input  busy, done, ok, mem_addr, mem_w_nr, mem_wdata
    );

    modport slave (
        input  start, x_pos, y_pos, ship_len, vertical, mem_rdata,
        output busy, done, ok, mem_addr, mem_w_nr, mem_wdata
    );
endinterface

// File: rtl/ship_placer.sv
// rtl/ship_placer.sv - places one ship on the board: edge check, overlap scan, then cell writes
module ship_placer #(
    parameter int X_SIZE       = 12,
    parameter int Y_SIZE       = 12,
    parameter int X_ADDR_WIDTH = 4,
    parameter int Y_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH   = 2,
    parameter int MAX_LEN      = 4,
    parameter logic [DATA_WIDTH-1:0] SHIP_CODE = 2'b01
) (
    input logic         clk,
    input logic         rst,
    ship_placer_if.slave bus
);
    localparam logic [X_ADDR_WIDTH:0] X_LAST  = (X_ADDR_WIDTH+1)'(X_SIZE - 1);
    localparam logic [Y_ADDR_WIDTH:0] Y_LAST  = (Y_ADDR_WIDTH+1)'(Y_SIZE - 1);
    localparam logic [2:0]            LEN_MAX = 3'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_BOUND, S_RD, S_CMP, S_WR, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [X_ADDR_WIDTH-1:0] x_q, x_d;
    logic [Y_ADDR_WIDTH-1:0] y_q, y_d;
    logic [2:0]              len_q, len_d;
    logic                    vert_q, vert_d;
    logic [2:0]              idx_q, idx_d;
    logic                    ok_q, ok_d;

    logic [X_ADDR_WIDTH:0]   x_end;
    logic [Y_ADDR_WIDTH:0]   y_end;
    logic                    reject;
    logic                    last_cell;
    logic [X_ADDR_WIDTH-1:0] cell_x;
    logic [Y_ADDR_WIDTH-1:0] cell_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            len_q   <= '0;
            vert_q  <= 1'b0;
            idx_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            len_q   <= len_d;
            vert_q  <= vert_d;
            idx_q   <= idx_d;
            ok_q    <= ok_d;
        end
    end

    // End coordinates carry one extra bit so a long ship near the edge cannot wrap back in range.
    always_comb begin
        x_end     = {1'b0, x_q} + (X_ADDR_WIDTH+1)'(len_q - 3'd1);
        y_end     = {1'b0, y_q} + (Y_ADDR_WIDTH+1)'(len_q - 3'd1);
        reject    = (len_q == 3'd0) || (len_q > LEN_MAX) ||
                    ({1'b0, x_q} > X_LAST) || ({1'b0, y_q} > Y_LAST) ||
                    (vert_q ? (y_end > Y_LAST) : (x_end > X_LAST));
        last_cell = (idx_q == len_q - 3'd1);
        cell_x    = vert_q ? x_q : x_q + X_ADDR_WIDTH'(idx_q);
        cell_y    = vert_q ? y_q + Y_ADDR_WIDTH'(idx_q) : y_q;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        len_d   = len_q;
        vert_d  = vert_q;
        idx_d   = idx_q;
        ok_d    = ok_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x_d     = bus.x_pos;
                    y_d     = bus.y_pos;
                    len_d   = bus.ship_len;
                    vert_d  = bus.vertical;
                    ok_d    = 1'b0;
                    state_d = S_BOUND;
                end
            end
            S_BOUND: begin
                idx_d   = 3'd0;
                state_d = reject ? S_DONE : S_RD;
            end
            S_RD: state_d = S_CMP;
            S_CMP: begin
                if (bus.mem_rdata != '0) begin
                    state_d = S_DONE;
                end else if (last_cell) begin
                    idx_d   = 3'd0;
                    state_d = S_WR;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_RD;
                end
            end
            S_WR: begin
                if (last_cell) begin
                    idx_d   = 3'd0;
                    ok_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.ok        = ok_q;
    assign bus.mem_addr  = (state_q == S_RD || state_q == S_CMP || state_q == S_WR) ?
                           {cell_x, cell_y} : '0;
    assign bus.mem_w_nr  = (state_q == S_WR);
    assign bus.mem_wdata = (state_q == S_WR) ? SHIP_CODE : '0;
endmodule

// File: tb/tb_ship_placer.sv
// tb/tb_ship_placer.sv - directed and random placement requests against a board-level reference
module tb_ship_placer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   clr_req = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [1:0] mem [0:255];
    int         ref_b [0:11][0:11];

    ship_placer_if bus ();

    ship_placer dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= 2'b00;
        end else if (bus.mem_w_nr) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 12; i++)
            for (int j = 0; j < 12; j++) ref_b[i][j] = 0;
        @(negedge clk); clr_req = 1'b1;
        @(negedge clk); clr_req = 1'b0;
    endtask

    task automatic check_board();
        for (int i = 0; i < 12; i++)
            for (int j = 0; j < 12; j++)
                chk($sformatf("board_%0d_%0d", i, j), 32'(mem[i*16+j]), 32'(ref_b[i][j]));
    endtask

    // Outcome derived from the placement rules: edges, then first occupied cell, then writes.
    task automatic run_req(input int x, input int y, input int len, input bit vert,
                           input bit dbl_start, input int rst_at);
        int  cx [4];
        int  cy [4];
        int  exp_done, exp_nw, coll, nw, done_cyc;
        bit  exp_ok, in_b;
        in_b = (len >= 1) && (len <= 4) && (x < 12) && (y < 12) &&
               ((vert ? y + len - 1 : x + len - 1) <= 11);
        exp_ok = 1'b0; exp_nw = 0; exp_done = 2; coll = -1;
        if (in_b) begin
            for (int k = 0; k < len; k++) begin
                cx[k] = vert ? x : x + k;
                cy[k] = vert ? y + k : y;
                if (coll < 0 && ref_b[cx[k]][cy[k]] != 0) coll = k;
            end
            if (coll >= 0) exp_done = 2*coll + 4;
            else begin exp_done = 3*len + 2; exp_ok = 1'b1; exp_nw = len; end
        end
        @(negedge clk);
        bus.start = 1'b1; bus.x_pos = 4'(x); bus.y_pos = 4'(y);
        bus.ship_len = 3'(len); bus.vertical = vert;
        @(posedge clk);
        nw = 0; done_cyc = -1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            bus.start    = dbl_start && (cyc == 3 || cyc == 5);
            bus.x_pos    = 4'($urandom);
            bus.y_pos    = 4'($urandom);
            bus.ship_len = 3'($urandom);
            bus.vertical = 1'($urandom);
            chk("busy_high", 32'(bus.busy), 32'd1);
            if (bus.mem_w_nr) begin
                chk("write_allowed", 32'(nw < exp_nw), 32'd1);
                if (nw < exp_nw) begin
                    chk("write_addr", 32'(bus.mem_addr), 32'(cx[nw]*16 + cy[nw]));
                    chk("write_cycle", 32'(cyc), 32'(2*len + 2 + nw));
                    chk("write_data", 32'(bus.mem_wdata), 32'd1);
                end
                nw++;
            end
            if (rst_at == cyc) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_done", 32'(bus.done), 32'd0);
                chk("rst_ok", 32'(bus.ok), 32'd0);
                chk("rst_addr", 32'(bus.mem_addr), 32'd0);
                chk("rst_w_nr", 32'(bus.mem_w_nr), 32'd0);
                chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
                // Writes presented up to and including the reset edge reach the memory.
                for (int k = 0; k < exp_nw; k++)
                    if (2*len + 2 + k <= rst_at) ref_b[cx[k]][cy[k]] = 1;
                @(negedge clk);
                chk("rst_first_cell", 32'(mem[cx[0]*16 + cy[0]]), 32'd1);
                chk("rst_last_cell", 32'(mem[cx[len-1]*16 + cy[len-1]]), 32'd0);
                return;
            end
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            chk("ok_cleared", 32'(bus.ok), 32'd0);
        end
        bus.start = 1'b0;
        chk("done_cycle", 32'(done_cyc), 32'(exp_done));
        chk("ok_at_done", 32'(bus.ok), 32'(exp_ok));
        chk("write_count", 32'(nw), 32'(exp_nw));
        if (exp_ok)
            for (int k = 0; k < len; k++) ref_b[cx[k]][cy[k]] = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("idle_done", 32'(bus.done), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("ok_held", 32'(bus.ok), 32'(exp_ok));
            chk("idle_w_nr", 32'(bus.mem_w_nr), 32'd0);
        end
        check_board();
    endtask

    initial begin
        bus.start = 1'b0; bus.x_pos = '0; bus.y_pos = '0;
        bus.ship_len = '0; bus.vertical = 1'b0;
        for (int i = 0; i < 12; i++)
            for (int j = 0; j < 12; j++) ref_b[i][j] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0; clr_req = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_ok", 32'(bus.ok), 32'd0);
        chk("reset_addr", 32'(bus.mem_addr), 32'd0);
        chk("reset_w_nr", 32'(bus.mem_w_nr), 32'd0);
        chk("reset_wdata", 32'(bus.mem_wdata), 32'd0);

        run_req(2, 3, 3, 1'b0, 1'b0, 0);
        run_req(3, 1, 4, 1'b1, 1'b0, 0);
        run_req(9, 0, 4, 1'b0, 1'b0, 0);
        run_req(8, 0, 4, 1'b0, 1'b0, 0);
        run_req(0, 5, 0, 1'b0, 1'b0, 0);
        run_req(0, 5, 5, 1'b1, 1'b0, 0);
        run_req(15, 15, 1, 1'b0, 1'b0, 0);
        run_req(0, 8, 2, 1'b0, 1'b1, 0);
        run_req(5, 10, 3, 1'b0, 1'b0, 9);
        run_req(5, 11, 3, 1'b0, 1'b0, 0);
        run_req(11, 8, 4, 1'b1, 1'b0, 0);

        for (int r = 0; r < 40; r++) begin
            if (r % 10 == 0) clear_board();
            run_req(int'($urandom_range(0, 13)), int'($urandom_range(0, 13)),
                    int'($urandom_range(0, 5)), 1'($urandom), 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ship_placer.md
Name: ship_placer

Overview:
- Sequences placement of one ship onto the 12x12 player board memory.
- Takes a request for a bow coordinate, a length and an orientation, and checks the request against the board edges.
- Reads every target cell to detect overlap with an existing ship, then writes the SHIP code into each cell.
- Sits between the placement UI/game FSM and the slow-clock port (addr1/w_nr/write_data1/read_data1) of the board memory. It is the only master of that port during placement.

Parameters:
X_SIZE, 12, board columns (valid x 0..X_SIZE-1)
Y_SIZE, 12, board rows (valid y 0..Y_SIZE-1)
X_ADDR_WIDTH, 4, x coordinate width
Y_ADDR_WIDTH, 4, y coordinate width
DATA_WIDTH, 2, cell code width
MAX_LEN, 4, longest legal ship
SHIP_CODE, 2'b01, value written to occupied cells (2'b00 = empty)

Ports:
clk  input  1  system clock (same clock as the memory's clk1)
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request pulse, sampled only in IDLE
x_pos  input  X_ADDR_WIDTH  bow column
y_pos  input  Y_ADDR_WIDTH  bow row
ship_len  input  3  ship length in cells
vertical  input  1  1 = ship extends +y, 0 = ship extends +x
busy  output  1  high from the cycle after start was accepted through the DONE cycle
done  output  1  one-cycle completion pulse
ok  output  1  result of the last request (1 = placed); valid from done, held until the next accepted start
mem_addr  output  X_ADDR_WIDTH+Y_ADDR_WIDTH  {x[7:4], y[3:0]}
mem_w_nr  output  1  1 = write, 0 = read
mem_wdata  output  DATA_WIDTH  write data
mem_rdata  input  DATA_WIDTH  memory read data; registered, valid the cycle after the address is presented with mem_w_nr=0

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; busy=0, done=0, ok=0, mem_addr=0, mem_w_nr=0, mem_wdata=0. All internal counters and latched request fields are cleared.
- Reset mid-operation: aborts immediately. Cells already written stay written; no rollback. The next cycle shows reset values.
- IDLE: if start=1, latch x_pos, y_pos, ship_len and vertical, clear ok, go to BOUND. Changes on the request inputs after acceptance are ignored.
- start while busy=1 is ignored; it is neither queued nor flagged.
- BOUND (1 cycle): reject if any of the following holds:
  - ship_len == 0
  - ship_len > MAX_LEN
  - x >= X_SIZE or y >= Y_SIZE
  - the end coordinate (varying axis + ship_len - 1), computed one bit wider than the coordinate so there is no wrap, is greater than the last valid index.
  - Reject goes to DONE with ok=0. Otherwise set the cell index i=0 and go to RD.
- Cell i address: horizontal = {x+i, y}; vertical = {x, y+i}.
- RD (1 cycle): mem_addr = cell i, mem_w_nr=0. Go to CMP.
- CMP (1 cycle): hold mem_addr. If mem_rdata != 0, go to DONE with ok=0 (collision). Else, if i == len-1, set i=0 and go to WR; otherwise increment i and go to RD.
- WR (len cycles): mem_addr = cell i, mem_w_nr=1, mem_wdata=SHIP_CODE. Increment i each cycle. After the cycle with i == len-1, set ok=1 and go to DONE.
- DONE (1 cycle): done=1, busy=1. Go to IDLE.
- Outside WR: mem_w_nr=0 and mem_wdata=0. In IDLE, mem_addr=0.
- Latency, counting cycle 0 as the edge at which start is sampled:
  - BOUND = cycle 1.
  - Accepted request of length L: done at cycle 3L+2.
  - Bound reject: done at cycle 2.
  - Collision at cell k: done at cycle 2k+4.
- No memory write occurs before every cell has been checked, so a rejected request never modifies the board.
- Read/compare never overlaps a write. The memory's read-before-write behaviour is irrelevant.

Test Plan:
- Empty board; start with x=2, y=3, len=3, vertical=0. Required: done at cycle 11 with ok=1. Write cycles at 8..10 with addr 0x23, 0x33, 0x43 and wdata=01. Memory afterwards holds exactly those three cells = 01.
- Same board; start with x=3, y=1, len=4, vertical=1. Target cells are (3,1), (3,2), (3,3), (3,4); (3,3) is already occupied, so k=2. Required: done at cycle 8 with ok=0, mem_w_nr never 1, memory unchanged.
- Bound cases:
  - x=9, len=4, vertical=0: end column 12 is out of range. Required: done at cycle 2, ok=0.
  - x=8, len=4, vertical=0: end column 11 is in range. Required: ok=1, last write addr 0xB?-column row y.
  - len=0 and len=5: each required to give done at cycle 2, ok=0.
- x=15, y=15, len=1: required to be rejected (x >= X_SIZE), with no 4-bit wrap.
- start pulsed again at cycles 3 and 5 of an accepted len=2 request. Required: ignored; exactly one done pulse; busy stays high from cycle 1 through done.
- rst asserted at cycle 9 of a len=3 request (during WR, after one write). Required: next cycle all outputs 0, state IDLE, first cell remains 01. A new start then completes normally.
